// File: rtl/mode_state_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mode_state_arbiter_pkg
// Shared header for the hood mode controllers. The `define block carries the
// mode codes and default timing constants for sources that predate the
// package. The package re-exports them as typed constants plus small helpers
// used by the arbiter.
// ---------------------------------------------------------------------------
`ifndef MODE_STATE_ARBITER_DEFINES
`define MODE_STATE_ARBITER_DEFINES
`define MSA_MODE_WIDTH          3
`define MSA_MODE_OFF            3'd0
`define MSA_MODE_STANDBY        3'd1
`define MSA_MODE_LEVEL1         3'd2
`define MSA_MODE_LEVEL2         3'd3
`define MSA_MODE_LEVEL3         3'd4
`define MSA_MODE_CLEAN          3'd5
`define MSA_MODE_EXIT_DELAY     3'd6
`define MSA_CLK_TICKS_PER_SEC   100000000
`define MSA_LEVEL3_SECONDS      60
`define MSA_EXIT_DELAY_SECONDS  60
`define MSA_CLEAN_SECONDS       180
`endif

package mode_state_arbiter_pkg;

   localparam int MODE_WIDTH_DEF         = `MSA_MODE_WIDTH;
   localparam int CLK_TICKS_PER_SEC_DEF  = `MSA_CLK_TICKS_PER_SEC;
   localparam int LEVEL3_SECONDS_DEF     = `MSA_LEVEL3_SECONDS;
   localparam int EXIT_DELAY_SECONDS_DEF = `MSA_EXIT_DELAY_SECONDS;
   localparam int CLEAN_SECONDS_DEF      = `MSA_CLEAN_SECONDS;
   localparam int SEC_WIDTH_DEF          = 8;

   // Code 7 is deliberately not named: the arbiter recovers it to OFF.
   typedef enum logic [2:0] {
      MODE_OFF        = `MSA_MODE_OFF,
      MODE_STANDBY    = `MSA_MODE_STANDBY,
      MODE_LEVEL1     = `MSA_MODE_LEVEL1,
      MODE_LEVEL2     = `MSA_MODE_LEVEL2,
      MODE_LEVEL3     = `MSA_MODE_LEVEL3,
      MODE_CLEAN      = `MSA_MODE_CLEAN,
      MODE_EXIT_DELAY = `MSA_MODE_EXIT_DELAY
   } mode_e;

   // Modes that run off the seconds counter.
   function automatic logic is_timed(input mode_e m);
      logic t;
      case (m)
         MODE_LEVEL3,
         MODE_CLEAN,
         MODE_EXIT_DELAY: t = 1'b1;
         default:         t = 1'b0;
      endcase
      return t;
   endfunction

   // Resolve a level request to its target mode: the highest set bit wins.
   // A level-3 request after level 3 was used this session resolves to the
   // current mode, i.e. it is swallowed rather than falling back to a lower
   // bit.
   function automatic mode_e level_target(input logic [2:0] req,
                                          input logic       l3_used,
                                          input mode_e      cur);
      mode_e t;
      if (req[2]) begin
         if (l3_used) begin
            t = cur;
         end else begin
            t = MODE_LEVEL3;
         end
      end else if (req[1]) begin
         t = MODE_LEVEL2;
      end else if (req[0]) begin
         t = MODE_LEVEL1;
      end else begin
         t = cur;
      end
      return t;
   endfunction

endpackage

// File: rtl/mode_state_arbiter_if.sv
// ---------------------------------------------------------------------------
// mode_state_arbiter_if
// Request/status bundle between the per-mode controllers and the arbiter.
//   master : controllers - drive the toggle pulses, read the mode status
//   slave  : arbiter     - reads the pulses, drives the mode status
// Signals: power_toggle, off_mode_toggle, standby_toggle, clean_toggle,
//          level_req[2:0]  (requests)
//          current_mode, mode_changed, remaining_seconds, level3_used (status)
// ---------------------------------------------------------------------------
interface mode_state_arbiter_if #(
   parameter int MODE_WIDTH = 3,
   parameter int SEC_WIDTH  = 8
);
   logic                  power_toggle;
   logic                  off_mode_toggle;
   logic                  standby_toggle;
   logic [2:0]            level_req;
   logic                  clean_toggle;
   logic [MODE_WIDTH-1:0] current_mode;
   logic                  mode_changed;
   logic [SEC_WIDTH-1:0]  remaining_seconds;
   logic                  level3_used;

   modport master (
      output power_toggle, off_mode_toggle, standby_toggle, level_req, clean_toggle,
      input  current_mode, mode_changed, remaining_seconds, level3_used
   );

   modport slave (
      input  power_toggle, off_mode_toggle, standby_toggle, level_req, clean_toggle,
      output current_mode, mode_changed, remaining_seconds, level3_used
   );
endinterface

// File: rtl/mode_state_arbiter_second_tick.sv
// ---------------------------------------------------------------------------
// second_tick_generator
// Prescaler that produces a one-cycle sec_tick every CLK_TICKS_PER_SEC clocks.
// A synchronous clear restarts the count so the next second is a full one.
// Ports: clk, rstn (async active-low), clear (sync restart), sec_tick (out).
// ---------------------------------------------------------------------------
module second_tick_generator #(
   parameter int CLK_TICKS_PER_SEC = 100000000
) (
   input  logic clk,
   input  logic rstn,
   input  logic clear,
   output logic sec_tick
);
   localparam int CNT_W = (CLK_TICKS_PER_SEC > 1) ? $clog2(CLK_TICKS_PER_SEC) : 1;

   logic [CNT_W-1:0] cnt_r;
   logic             tick_s;

   // Terminal count decode of the prescaler.
   always_comb begin
      tick_s = (cnt_r == CNT_W'(CLK_TICKS_PER_SEC - 1));
   end

   assign sec_tick = tick_s;

   // Prescaler: restart on clear or on wrap.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (clear || tick_s) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end
endmodule

// File: rtl/mode_state_arbiter.sv
// ---------------------------------------------------------------------------
// mode_state_arbiter
// Single owner of the hood's current_mode. Arbitrates one-cycle toggle
// requests from the mode controllers and runs the timed modes (level-3
// session limit, exit delay, self-clean) off a shared one-second tick.
// Ports:
//   clk   - system clock
//   rstn  - asynchronous active-low reset
//   bus   - slave side of mode_state_arbiter_if (requests in, status out)
// ---------------------------------------------------------------------------
module mode_state_arbiter
   import mode_state_arbiter_pkg::*;
#(
   parameter int MODE_WIDTH         = MODE_WIDTH_DEF,
   parameter int CLK_TICKS_PER_SEC  = CLK_TICKS_PER_SEC_DEF,
   parameter int LEVEL3_SECONDS     = LEVEL3_SECONDS_DEF,
   parameter int EXIT_DELAY_SECONDS = EXIT_DELAY_SECONDS_DEF,
   parameter int CLEAN_SECONDS      = CLEAN_SECONDS_DEF,
   parameter int SEC_WIDTH          = SEC_WIDTH_DEF
) (
   input logic                  clk,
   input logic                  rstn,
   mode_state_arbiter_if.slave  bus
);

   mode_e                mode_r;
   mode_e                mode_nxt_s;
   logic [SEC_WIDTH-1:0] rem_r;
   logic [SEC_WIDTH-1:0] rem_nxt_s;
   logic                 l3_used_r;
   logic                 l3_used_nxt_s;
   logic                 changed_r;
   logic                 changed_nxt_s;
   logic                 raw_tick_s;
   logic                 tick_s;
   logic                 expire_s;
   logic                 presc_clr_s;

   // Countdown load value for a mode being entered; untimed modes show 0.
   function automatic logic [SEC_WIDTH-1:0] seconds_for(input mode_e m);
      logic [SEC_WIDTH-1:0] s;
      case (m)
         MODE_LEVEL3:     s = SEC_WIDTH'(LEVEL3_SECONDS);
         MODE_EXIT_DELAY: s = SEC_WIDTH'(EXIT_DELAY_SECONDS);
         MODE_CLEAN:      s = SEC_WIDTH'(CLEAN_SECONDS);
         default:         s = {SEC_WIDTH{1'b0}};
      endcase
      return s;
   endfunction

   second_tick_generator #(
      .CLK_TICKS_PER_SEC (CLK_TICKS_PER_SEC)
   ) u_second_tick (
      .clk      (clk),
      .rstn     (rstn),
      .clear    (presc_clr_s),
      .sec_tick (raw_tick_s)
   );

   // Tick qualification: only timed modes count seconds; expiry is the tick
   // that would take the counter from 1 to 0.
   always_comb begin
      tick_s   = raw_tick_s && is_timed(mode_r);
      expire_s = tick_s && (rem_r == SEC_WIDTH'(1));
   end

   // Next-mode arbitration. Off outranks everything outside OFF; the rest
   // follows clean > L3 > L2 > L1 > standby, filtered by what each mode accepts.
   always_comb begin
      mode_nxt_s = mode_r;
      case (mode_r)
         MODE_OFF: begin
            if (bus.power_toggle) begin
               mode_nxt_s = MODE_STANDBY;
            end else begin
               mode_nxt_s = MODE_OFF;
            end
         end
         MODE_STANDBY: begin
            if (bus.off_mode_toggle) begin
               mode_nxt_s = MODE_OFF;
            end else if (bus.clean_toggle) begin
               mode_nxt_s = MODE_CLEAN;
            end else if (|bus.level_req) begin
               mode_nxt_s = level_target(bus.level_req, l3_used_r, mode_r);
            end else begin
               mode_nxt_s = mode_r;
            end
         end
         MODE_LEVEL1,
         MODE_LEVEL2: begin
            // Clean is not accepted here, so it does not mask level/standby.
            if (bus.off_mode_toggle) begin
               mode_nxt_s = MODE_OFF;
            end else if (|bus.level_req) begin
               mode_nxt_s = level_target(bus.level_req, l3_used_r, mode_r);
            end else if (bus.standby_toggle) begin
               mode_nxt_s = MODE_STANDBY;
            end else begin
               mode_nxt_s = mode_r;
            end
         end
         MODE_LEVEL3: begin
            // A user standby request takes precedence over a coincident expiry.
            if (bus.off_mode_toggle) begin
               mode_nxt_s = MODE_OFF;
            end else if (bus.standby_toggle) begin
               mode_nxt_s = MODE_EXIT_DELAY;
            end else if (expire_s) begin
               mode_nxt_s = MODE_LEVEL2;
            end else begin
               mode_nxt_s = mode_r;
            end
         end
         MODE_EXIT_DELAY,
         MODE_CLEAN: begin
            if (bus.off_mode_toggle) begin
               mode_nxt_s = MODE_OFF;
            end else if (expire_s) begin
               mode_nxt_s = MODE_STANDBY;
            end else begin
               mode_nxt_s = mode_r;
            end
         end
         default: begin
            // Illegal code: fall back to the safe state.
            mode_nxt_s = MODE_OFF;
         end
      endcase
   end

   // Countdown, level-3 session flag, change pulse and prescaler restart.
   always_comb begin
      changed_nxt_s = (mode_nxt_s != mode_r);
      rem_nxt_s     = rem_r;
      l3_used_nxt_s = l3_used_r;
      if (changed_nxt_s) begin
         rem_nxt_s = seconds_for(mode_nxt_s);
         if (mode_nxt_s == MODE_LEVEL3) begin
            l3_used_nxt_s = 1'b1;
         end else if (mode_nxt_s == MODE_OFF) begin
            l3_used_nxt_s = 1'b0;
         end else begin
            l3_used_nxt_s = l3_used_r;
         end
      end else if (!is_timed(mode_r)) begin
         rem_nxt_s = {SEC_WIDTH{1'b0}};
      end else if (tick_s) begin
         rem_nxt_s = rem_r - SEC_WIDTH'(1);
      end else begin
         rem_nxt_s = rem_r;
      end
      // Restarting on every mode change makes the first second after entry full.
      presc_clr_s = changed_nxt_s || !is_timed(mode_r);
   end

   // State and registered status outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mode_r    <= MODE_OFF;
         rem_r     <= {SEC_WIDTH{1'b0}};
         l3_used_r <= 1'b0;
         changed_r <= 1'b0;
      end else begin
         mode_r    <= mode_nxt_s;
         rem_r     <= rem_nxt_s;
         l3_used_r <= l3_used_nxt_s;
         changed_r <= changed_nxt_s;
      end
   end

   assign bus.current_mode      = MODE_WIDTH'(mode_r);
   assign bus.mode_changed      = changed_r;
   assign bus.remaining_seconds = rem_r;
   assign bus.level3_used       = l3_used_r;

endmodule
